// File: rtl/pixel_writer.sv
// Gathers 6 or 8 pixel FIFO words into one 256-bit Avalon-MM write, optionally expanding 3-byte pixels to 4 bytes.
// The write holds while waitrequest is high; one outstanding write at a time; FIFO reads stall on empty.
module pixel_writer #(
  parameter int USEDW_W      = 10,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        avl_mm_addr,
  output logic               avl_mm_write,
  output logic [255:0]       avl_mm_writedata,
  output logic [31:0]        avl_mm_byteenable,
  input  logic               avl_mm_waitrequest,
  input  logic               avl_mm_writeresponsevalid,
  input  logic [1:0]         avl_mm_response,
  output logic               pix_fifo_read,
  input  logic [31:0]        pix_fifo_data,
  input  logic               pix_fifo_empty,
  input  logic [USEDW_W-1:0] pix_fifo_usedw,
  input  logic               enable,
  input  logic               word_mode,
  input  logic [31:0]        base_address,
  input  logic [31:0]        total_size,
  input  logic [USEDW_W-1:0] pix_fifo_threshold,
  input  logic               transform_data,
  output logic               write_error,
  output logic               error_sticky,
  output logic               frame_done,
  output logic               active
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, RESP} state_t;

  state_t       state_q, state_d;
  logic [3:0]   issued_cnt, captured_cnt, burst_n;
  logic         rd_pending;
  logic [255:0] buffer;
  logic         burst_xform, burst_word_mode;
  logic [31:0]  cur_addr, latched_base, resp_timer;
  logic [31:0]  next_addr, frame_end;
  logic         enable_d;
  logic         start_burst, resp_ok, resp_err;

  assign burst_n           = burst_xform ? 4'd6 : 4'd8;
  assign next_addr         = cur_addr + (burst_word_mode ? 32'd8 : 32'd32);
  assign frame_end         = latched_base + total_size;
  assign avl_mm_addr       = cur_addr;
  assign avl_mm_byteenable = '1;
  assign active            = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    start_burst   = 1'b0;
    resp_ok       = 1'b0;
    resp_err      = 1'b0;
    pix_fifo_read = 1'b0;
    avl_mm_write  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !error_sticky && (pix_fifo_usedw >= pix_fifo_threshold)) begin
          start_burst = 1'b1;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        pix_fifo_read = (issued_cnt < burst_n) && !pix_fifo_empty;
        if (rd_pending && (captured_cnt == burst_n - 4'd1))
          state_d = WRITE;
      end
      WRITE: begin
        avl_mm_write = 1'b1;
        if (!avl_mm_waitrequest)
          state_d = RESP;
      end
      RESP: begin
        if (avl_mm_writeresponsevalid) begin
          resp_ok  = (avl_mm_response == 2'b00);
          resp_err = (avl_mm_response != 2'b00);
          state_d  = IDLE;
        end else if (resp_timer == 32'(RESP_TIMEOUT - 1)) begin
          resp_err = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // 3-byte pixels sit back to back in the buffer; each gets a zero top byte.
  always_comb begin
    avl_mm_writedata = buffer;
    if (burst_xform) begin
      for (int i = 0; i < 8; i++)
        avl_mm_writedata[32*i +: 32] = {8'h00, buffer[24*i +: 24]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt      <= '0;
      captured_cnt    <= '0;
      rd_pending      <= 1'b0;
      buffer          <= '0;
      burst_xform     <= 1'b0;
      burst_word_mode <= 1'b0;
      cur_addr        <= '0;
      latched_base    <= '0;
      resp_timer      <= '0;
      enable_d        <= 1'b0;
      write_error     <= 1'b0;
      error_sticky    <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      write_error <= 1'b0;
      frame_done  <= 1'b0;
      enable_d    <= enable;
      rd_pending  <= pix_fifo_read;

      if (start_burst) begin
        issued_cnt      <= '0;
        captured_cnt    <= '0;
        burst_xform     <= transform_data;
        burst_word_mode <= word_mode;
      end
      if (pix_fifo_read)
        issued_cnt <= issued_cnt + 4'd1;
      // Non-show-ahead FIFO: data belongs to the read strobed one cycle earlier.
      if (rd_pending) begin
        buffer[{captured_cnt[2:0], 5'd0} +: 32] <= pix_fifo_data;
        captured_cnt <= captured_cnt + 4'd1;
      end

      if (state_q == WRITE)     resp_timer <= '0;
      else if (state_q == RESP) resp_timer <= resp_timer + 32'd1;

      if (resp_ok) begin
        if (next_addr == frame_end) begin
          cur_addr   <= latched_base;
          frame_done <= 1'b1;
        end else begin
          cur_addr <= next_addr;
        end
      end

      if (resp_err) begin
        write_error  <= 1'b1;
        error_sticky <= 1'b1;
      end else if ((state_q == IDLE) && !enable) begin
        error_sticky <= 1'b0;
      end

      if (enable && !enable_d) begin
        latched_base <= base_address;
        cur_addr     <= base_address;
      end
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: FIFO and Avalon slave responders, scenario table, random scenarios, reset corners.
module tb_pixel_writer;
  localparam int UW  = 10;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0]   avl_mm_addr;
  logic          avl_mm_write;
  logic [255:0]  avl_mm_writedata;
  logic [31:0]   avl_mm_byteenable;
  logic          avl_mm_waitrequest = 1'b0;
  logic          avl_mm_writeresponsevalid = 1'b0;
  logic [1:0]    avl_mm_response = 2'b00;
  logic          pix_fifo_read;
  logic [31:0]   pix_fifo_data = '0;
  logic          pix_fifo_empty = 1'b1;
  logic [UW-1:0] pix_fifo_usedw = '0;
  logic          enable = 1'b0, word_mode = 1'b0, transform_data = 1'b0;
  logic [31:0]   base_address = '0, total_size = '0;
  logic [UW-1:0] pix_fifo_threshold = 10'd1;
  logic          write_error, error_sticky, frame_done, active;

  pixel_writer #(.USEDW_W(UW), .RESP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .avl_mm_addr(avl_mm_addr), .avl_mm_write(avl_mm_write),
    .avl_mm_writedata(avl_mm_writedata), .avl_mm_byteenable(avl_mm_byteenable),
    .avl_mm_waitrequest(avl_mm_waitrequest),
    .avl_mm_writeresponsevalid(avl_mm_writeresponsevalid),
    .avl_mm_response(avl_mm_response),
    .pix_fifo_read(pix_fifo_read), .pix_fifo_data(pix_fifo_data),
    .pix_fifo_empty(pix_fifo_empty), .pix_fifo_usedw(pix_fifo_usedw),
    .enable(enable), .word_mode(word_mode), .base_address(base_address),
    .total_size(total_size), .pix_fifo_threshold(pix_fifo_threshold),
    .transform_data(transform_data),
    .write_error(write_error), .error_sticky(error_sticky),
    .frame_done(frame_done), .active(active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder configuration and observations
  logic [31:0]  fifo_q[$];
  logic [31:0]  words[$];
  logic [31:0]  acc_addr_q[$];
  logic [255:0] acc_data_q[$];
  bit           stall_en = 1'b0;
  bit           resp_drop = 1'b0;
  logic [1:0]   resp_code_cfg = 2'b00;
  int           wait_cfg = 0, resp_delay = 1;
  int           n_reads = 0, n_frames = 0, n_errs = 0, n_active = 0, n_unstable = 0;
  int           cyc = 0, acc_cyc = 0, err_cyc = 0, last_len = 0;

  // Non-show-ahead FIFO: data appears the cycle after the read strobe.
  bit rd_seen;
  always begin
    @(negedge clk);
    rd_seen = pix_fifo_read;
    @(posedge clk);
    #1;
    if (rd_seen) begin
      n_reads++;
      if (fifo_q.size() > 0) pix_fifo_data = fifo_q.pop_front();
    end
    pix_fifo_empty = (fifo_q.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));
    pix_fifo_usedw = UW'(fifo_q.size());
  end

  // Avalon slave plus output monitors
  bit           wr_hi, acc;
  int           wait_left = 0, resp_cnt = -1, cur_len = 0;
  logic [31:0]  hold_addr;
  logic [255:0] hold_data;
  always begin
    @(negedge clk);
    cyc++;
    if (frame_done) n_frames++;
    if (write_error) begin n_errs++; err_cyc = cyc; end
    if (active) n_active++;
    wr_hi = avl_mm_write;
    acc   = avl_mm_write && !avl_mm_waitrequest;
    if (wr_hi) begin
      if (cur_len > 0 && (avl_mm_addr !== hold_addr || avl_mm_writedata !== hold_data)) n_unstable++;
      hold_addr = avl_mm_addr;
      hold_data = avl_mm_writedata;
      cur_len++;
    end else begin
      cur_len = 0;
    end
    if (acc) begin
      acc_addr_q.push_back(avl_mm_addr);
      acc_data_q.push_back(avl_mm_writedata);
      last_len = cur_len;
      cur_len  = 0;
      acc_cyc  = cyc;
      resp_cnt = resp_drop ? -1 : resp_delay;
    end
    @(posedge clk);
    #1;
    avl_mm_writeresponsevalid = 1'b0;
    avl_mm_response = 2'b00;
    if (resp_cnt == 0) begin
      avl_mm_writeresponsevalid = 1'b1;
      avl_mm_response = resp_code_cfg;
    end
    if (resp_cnt >= 0) resp_cnt--;
    if (!wr_hi || acc) wait_left = wait_cfg;
    else if (wait_left > 0) wait_left--;
    avl_mm_waitrequest = (wait_left > 0);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (active && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin
      checks++; errors++;
      $display("FAIL %s: DUT still active after %0d cycles", nm, t);
    end
  endtask

  task automatic wait_write(input string nm);
    int t = 0;
    while (!avl_mm_write && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin
      checks++; errors++;
      $display("FAIL %s: no write request within %0d cycles", nm, t);
    end
  endtask

  // Reference: packed byte stream view of the FIFO words for one burst.
  function automatic logic [255:0] model_data(input bit xf, input int first);
    logic [7:0]   b[24];
    logic [255:0] d;
    d = '0;
    if (!xf) begin
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = words[first + i];
    end else begin
      for (int j = 0; j < 24; j++) b[j] = 8'(words[first + j / 4] >> (8 * (j % 4)));
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = {8'h00, b[3*i+2], b[3*i+1], b[3*i]};
    end
    return d;
  endfunction

  typedef struct {
    string       nm;
    bit          xf;
    bit          wm;
    logic [31:0] base;
    logic [31:0] total;
    int          pat;
    int          nwords;
    int          wait_c;
    logic [1:0]  rc;
    bit          drop;
    bit          stall;
    int          exp_w;
    int          exp_f;
    bit          exp_err;
    logic [31:0] exp_addr;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int n, step, fr0, er0, rd0, wb, un0, t, got;
    logic [31:0]  w, wsel;
    logic [255:0] dsel;
    enable = 1'b0;
    wait_idle({v.nm, " pre"});
    repeat (2) @(negedge clk);
    fifo_q.delete();
    words.delete();
    wait_cfg = v.wait_c; resp_code_cfg = v.rc; resp_drop = v.drop;
    resp_delay = $urandom_range(0, 3); stall_en = v.stall;
    transform_data = v.xf; word_mode = v.wm; base_address = v.base; total_size = v.total;
    pix_fifo_threshold = 10'd1;
    n = v.xf ? 6 : 8;
    step = v.wm ? 8 : 32;
    for (int k = 0; k < v.nwords; k++) begin
      if (v.pat == 1)      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      else if (v.pat == 2) w = 32'(k);
      else                 w = $urandom;
      words.push_back(w);
      fifo_q.push_back(w);
    end
    fr0 = n_frames; er0 = n_errs; rd0 = n_reads; wb = acc_addr_q.size(); un0 = n_unstable;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    t = 0;
    while (t < 3000 && !((acc_addr_q.size() - wb >= v.exp_w) && !active)) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) begin
      checks++; errors++;
      $display("FAIL %s done: writes not completed in %0d cycles", v.nm, t);
    end
    repeat (40) @(negedge clk);
    got = acc_addr_q.size() - wb;
    chk({v.nm, " writes"}, 256'(got), 256'(v.exp_w));
    for (int b = 0; b < v.exp_w && b < got; b++) begin
      chk($sformatf("%s addr%0d", v.nm, b), 256'(acc_addr_q[wb+b]),
          256'(v.base + 32'((b * step) % int'(v.total))));
      chk($sformatf("%s data%0d", v.nm, b), acc_data_q[wb+b], model_data(v.xf, b * n));
    end
    chk({v.nm, " frame_done"}, 256'(n_frames - fr0), 256'(v.exp_f));
    chk({v.nm, " write_error"}, 256'(n_errs - er0), 256'(v.exp_err ? 1 : 0));
    chk({v.nm, " sticky"}, 256'(error_sticky), 256'(v.exp_err));
    chk({v.nm, " next_addr"}, 256'(avl_mm_addr), 256'(v.exp_addr));
    chk({v.nm, " reads"}, 256'(n_reads - rd0), 256'(v.exp_w * n));
    chk({v.nm, " stable"}, 256'(n_unstable - un0), 256'(0));
    chk({v.nm, " wr_len"}, 256'(last_len), 256'(v.wait_c + 1));
    if (v.drop) chk({v.nm, " timeout"}, 256'(err_cyc - acc_cyc), 256'(TMO + 1));
    if (v.pat == 1 && got > 0) begin
      dsel = acc_data_q[wb];
      wsel = dsel[31:0];
      chk({v.nm, " word0"}, 256'(wsel), 256'(32'h0002_0100));
      wsel = dsel[255:224];
      chk({v.nm, " word7"}, 256'(wsel), 256'(32'h0017_1615));
    end
    if (v.pat == 2 && got > 1) begin
      dsel = acc_data_q[wb+1];
      wsel = dsel[31:0];
      chk({v.nm, " w2word0"}, 256'(wsel), 256'(32'd8));
    end
  endtask

  vec_t vecs[7];
  vec_t rv;
  int   wb0, a0, rn, rstep, rm, rbursts;

  initial begin
    //         nm        xf wm  base          total        pat nw wait rc   drop stall w f err addr
    vecs[0] = '{"seq16",  0, 0, 32'h0000_1000, 32'h40,      2, 16, 0, 2'b00, 0, 0, 2, 1, 0, 32'h0000_1000};
    vecs[1] = '{"xform",  1, 0, 32'h0000_2000, 32'h100,     1, 6,  0, 2'b00, 0, 0, 1, 0, 0, 32'h0000_2020};
    vecs[2] = '{"wait5",  0, 0, 32'h0000_3000, 32'h1000,    0, 8,  5, 2'b00, 0, 0, 1, 0, 0, 32'h0000_3020};
    vecs[3] = '{"resp10", 0, 0, 32'h0000_4000, 32'h1000,    0, 16, 1, 2'b10, 0, 0, 1, 0, 1, 32'h0000_4000};
    vecs[4] = '{"wmode",  0, 1, 32'h0000_0100, 32'h18,      0, 24, 2, 2'b00, 0, 1, 3, 1, 0, 32'h0000_0100};
    vecs[5] = '{"tmo",    0, 0, 32'h0000_5000, 32'h100,     0, 8,  0, 2'b00, 1, 0, 1, 0, 1, 32'h0000_5000};
    vecs[6] = '{"xf_wm",  1, 1, 32'h0000_0050, 32'h10,      0, 12, 0, 2'b00, 0, 1, 2, 1, 0, 32'h0000_0050};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst write", 256'(avl_mm_write), 256'(0));
    chk("rst addr", 256'(avl_mm_addr), 256'(0));
    chk("rst wdata", avl_mm_writedata, 256'(0));
    chk("rst read", 256'(pix_fifo_read), 256'(0));
    chk("rst flags", 256'({write_error, error_sticky, frame_done, active}), 256'(0));
    chk("byteenable", 256'(avl_mm_byteenable), 256'(32'hFFFF_FFFF));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fill level below threshold keeps the FSM idle
    pix_fifo_threshold = 10'd20;
    base_address = 32'h0000_6000; total_size = 32'h100;
    for (int k = 0; k < 8; k++) fifo_q.push_back(32'(k));
    wb0 = acc_addr_q.size();
    repeat (3) @(negedge clk);
    enable = 1'b1;
    a0 = n_active;
    repeat (30) @(negedge clk);
    chk("thresh active", 256'(n_active - a0), 256'(0));
    chk("thresh writes", 256'(acc_addr_q.size() - wb0), 256'(0));
    enable = 1'b0;
    pix_fifo_threshold = 10'd1;
    repeat (3) @(negedge clk);

    // Enable drops during WRITE: burst still completes, then stays idle
    fifo_q.delete();
    wait_cfg = 3; resp_code_cfg = 2'b00; resp_drop = 1'b0; resp_delay = 1;
    transform_data = 1'b0; word_mode = 1'b0;
    base_address = 32'h0000_8000; total_size = 32'h1000;
    for (int k = 0; k < 16; k++) fifo_q.push_back($urandom);
    wb0 = acc_addr_q.size();
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_write("enfall");
    enable = 1'b0;
    wait_idle("enfall");
    a0 = n_active;
    repeat (30) @(negedge clk);
    chk("enfall writes", 256'(acc_addr_q.size() - wb0), 256'(1));
    chk("enfall addr", 256'(avl_mm_addr), 256'(32'h0000_8020));
    chk("enfall idle", 256'(n_active - a0), 256'(0));

    // Reset while a write is stalled
    fifo_q.delete();
    wait_cfg = 10;
    for (int k = 0; k < 8; k++) fifo_q.push_back($urandom);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_write("midrst");
    rst_n = 1'b0;
    #1;
    chk("midrst write", 256'(avl_mm_write), 256'(0));
    chk("midrst read", 256'(pix_fifo_read), 256'(0));
    chk("midrst active", 256'(active), 256'(0));
    chk("midrst addr", 256'(avl_mm_addr), 256'(0));
    chk("midrst wdata", avl_mm_writedata, 256'(0));
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    for (int r = 0; r < 8; r++) begin
      rv.nm     = $sformatf("rnd%0d", r);
      rv.xf     = 1'($urandom_range(0, 1));
      rv.wm     = 1'($urandom_range(0, 1));
      rn        = rv.xf ? 6 : 8;
      rstep     = rv.wm ? 8 : 32;
      rm        = $urandom_range(1, 4);
      rbursts   = $urandom_range(1, 5);
      rv.base   = $urandom & 32'hFFFF_FFF8;
      rv.total  = 32'(rm * rstep);
      rv.pat    = 0;
      rv.nwords = rbursts * rn;
      rv.wait_c = $urandom_range(0, 3);
      rv.rc     = 2'b00;
      rv.drop   = 1'b0;
      rv.stall  = 1'($urandom_range(0, 1));
      rv.exp_w  = rbursts;
      rv.exp_f  = rbursts / rm;
      rv.exp_err  = 1'b0;
      rv.exp_addr = rv.base + 32'((rbursts * rstep) % (rm * rstep));
      run_vec(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter USEDW_W, default 10, pixel FIFO used-words width.
REQ-002 SHALL have parameter RESP_TIMEOUT, default 255, cycles to wait for a write response before flagging an error.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port avl_mm_addr  out  32  Avalon-MM master write address.
REQ-006 SHALL have port avl_mm_write  out  1  write request.
REQ-007 SHALL have port avl_mm_writedata  out  256  write data.
REQ-008 SHALL have port avl_mm_byteenable  out  32  byte enables, constant all ones.
REQ-009 SHALL have port avl_mm_waitrequest  in  1  slave stall.
REQ-010 SHALL have port avl_mm_writeresponsevalid  in  1  write response strobe.
REQ-011 SHALL have port avl_mm_response  in  2  response code, 0 = OK.
REQ-012 SHALL have port pix_fifo_read  out  1  FIFO read strobe; data valid 1 cycle later (non-show-ahead).
REQ-013 SHALL have port pix_fifo_data  in  32  FIFO read data.
REQ-014 SHALL have port pix_fifo_empty  in  1  FIFO empty.
REQ-015 SHALL have port pix_fifo_usedw  in  USEDW_W  FIFO fill level.
REQ-016 SHALL have ports enable, word_mode (1 word / 0 byte addressing), base_address[31:0], total_size[31:0], pix_fifo_threshold[USEDW_W-1:0], transform_data (1 = expand 3-byte pixels to 4-byte) -- all inputs.
REQ-017 SHALL have outputs write_error (1-cycle pulse), error_sticky, frame_done (1-cycle pulse), active.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, WRITE, RESP; active = (state != IDLE).
REQ-019 IDLE->COLLECT SHALL occur when enable=1, error_sticky=0 and pix_fifo_usedw >= pix_fifo_threshold.
REQ-020 Burst size N SHALL be 6 FIFO words when transform_data=1, else 8; transform_data and word_mode SHALL be sampled on IDLE->COLLECT and held for the burst.
REQ-021 In COLLECT, pix_fifo_read SHALL assert when issued-count < N and pix_fifo_empty=0; never more than N reads per burst.
REQ-022 Each returned word k (k=0..N-1) SHALL be stored at buffer bits [32k+:32].
REQ-023 transform_data=0: writedata SHALL equal the 8 buffered words unchanged.
REQ-024 transform_data=1: the 192 buffered bits SHALL be treated as 24 packed bytes; output word i (0..7) bytes[2:0] = packed bytes 3i..3i+2, byte[3] = 8'h00.
REQ-025 COLLECT->WRITE SHALL occur the cycle after the N-th word is captured; avl_mm_write=1 throughout WRITE, with addr/data stable.
REQ-026 WRITE->RESP SHALL occur on the cycle avl_mm_write=1 and waitrequest=0; avl_mm_write SHALL drop the next cycle.
REQ-027 In RESP, writeresponsevalid with response=0 SHALL go to IDLE; response!=0 or RESP_TIMEOUT cycles without response SHALL pulse write_error, set error_sticky, go to IDLE.
REQ-028 error_sticky SHALL clear only when enable=0 in IDLE.
REQ-029 On rising edge of enable, base_address SHALL be latched and the current address loaded with it.
REQ-030 After each successful response, address SHALL advance by 32 (word_mode=0) or 8 (word_mode=1), 32-bit wrap.
REQ-031 If the advanced address equals latched_base + total_size, address SHALL reload latched_base and frame_done SHALL pulse one cycle.
REQ-032 enable falling mid-burst SHALL not abort: the burst completes through RESP, then FSM stays IDLE.
REQ-033 On error the address SHALL not advance.

Reset
REQ-034 On rst_n=0 SHALL be: state IDLE, avl_mm_write=0, avl_mm_addr=0, writedata=0, pix_fifo_read=0, write_error=0, error_sticky=0, frame_done=0, active=0, counters 0.
REQ-035 Reset mid-burst SHALL immediately drop avl_mm_write and pix_fifo_read; no partial state survives.

Verification
REQ-036 transform_data=0, word_mode=0, base=0x1000, total_size=0x40, FIFO words 0..15 -> writes to 0x1000 then 0x1020 with words 0..7 / 8..15, frame_done pulse after second, next write at 0x1000.
REQ-037 transform_data=1, FIFO words 0x03020100,0x07060504,...(bytes 0..23) -> single write, word i = {8'h00, byte 3i+2, 3i+1, 3i}.
REQ-038 waitrequest held 5 cycles -> avl_mm_write and data stable 6 cycles, exactly one write accepted.
REQ-039 response=2'b10 -> write_error pulse, error_sticky=1, address unchanged, no new burst until enable toggles low/high.
REQ-040 pix_fifo_empty toggling during COLLECT -> reads stall, exactly N reads per burst, data order preserved.
REQ-041 usedw below threshold -> FSM stays IDLE; word_mode=1 -> address steps of 8.
